// File: rtl/food_spawner.sv
// Draws a random in-bounds food position that does not overlap the snake body, then commits it.
// Latency 3+snake_len cycles when the first draw is clean; spawn_req is ignored while busy (no queueing).
module food_spawner #(
    parameter int MAX_SEG   = 64,
    parameter int X_MIN     = 20,
    parameter int X_MAX     = 620,
    parameter int Y_MIN     = 20,
    parameter int Y_MAX     = 460,
    parameter int MAX_RETRY = 15,
    parameter int RST_X     = 320,
    parameter int RST_Y     = 240
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       spawn_req,
    input  logic [9:0] rand_X,
    input  logic [9:0] rand_Y,
    input  logic [6:0] snake_len,
    output logic [5:0] seg_idx,
    input  logic [9:0] seg_X,
    input  logic [9:0] seg_Y,
    output logic [9:0] food_X,
    output logic [9:0] food_Y,
    output logic       food_valid,
    output logic       busy,
    output logic       spawn_fail
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [9:0]    X_LO    = 10'(X_MIN);
    localparam logic [9:0]    X_HI    = 10'(X_MAX);
    localparam logic [9:0]    Y_LO    = 10'(Y_MIN);
    localparam logic [9:0]    Y_HI    = 10'(Y_MAX);
    localparam logic [9:0]    X_RST   = 10'(RST_X);
    localparam logic [9:0]    Y_RST   = 10'(RST_Y);
    localparam logic [6:0]    LEN_MAX = 7'(MAX_SEG);
    localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    cand_x_q, cand_x_d;
    logic [9:0]    cand_y_q, cand_y_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [5:0]    seg_idx_q, seg_idx_d;
    logic [9:0]    food_x_q, food_x_d;
    logic [9:0]    food_y_q, food_y_d;
    logic          food_valid_q, food_valid_d;
    logic          busy_q, busy_d;
    logic          spawn_fail_q, spawn_fail_d;

    logic [6:0] len_eff;
    logic       in_bounds;
    logic       hit;
    logic       collide;
    logic       scan_done;

    // cnt_q counts cycles spent on the current candidate: 0 is the bounds test,
    // address i is on the bus at cnt i+1 and its data is compared at cnt i+2.
    always_comb begin
        len_eff   = (snake_len > LEN_MAX) ? LEN_MAX : snake_len;
        in_bounds = (cand_x_q >= X_LO) && (cand_x_q <= X_HI) &&
                    (cand_y_q >= Y_LO) && (cand_y_q <= Y_HI);
        hit       = (cnt_q >= 7'd2) && (seg_X == cand_x_q) && (seg_Y == cand_y_q);
        collide   = ((cnt_q == 7'd0) && !in_bounds) || hit;
        scan_done = (cnt_q == len_eff + 7'd1);

        state_d      = state_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        retry_d      = retry_q;
        cnt_d        = cnt_q;
        seg_idx_d    = seg_idx_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        busy_d       = busy_q;
        spawn_fail_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (spawn_req) begin
                    cand_x_d     = rand_X;
                    cand_y_d     = rand_Y;
                    retry_d      = '0;
                    cnt_d        = '0;
                    seg_idx_d    = '0;
                    busy_d       = 1'b1;
                    food_valid_d = 1'b0;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                if (collide) begin
                    if (retry_q == RTY_MAX) begin
                        spawn_fail_d = 1'b1;
                        state_d      = COMMIT;
                    end else begin
                        retry_d   = retry_q + 1'b1;
                        cand_x_d  = rand_X;
                        cand_y_d  = rand_Y;
                        cnt_d     = '0;
                        seg_idx_d = '0;
                    end
                end else if (scan_done) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                    if ((cnt_q != 7'd0) && (cnt_q < len_eff)) begin
                        seg_idx_d = cnt_q[5:0];
                    end
                end
            end
            COMMIT: begin
                food_x_d     = cand_x_q;
                food_y_d     = cand_y_q;
                food_valid_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            retry_q      <= '0;
            cnt_q        <= '0;
            seg_idx_q    <= '0;
            food_x_q     <= X_RST;
            food_y_q     <= Y_RST;
            food_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            spawn_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            retry_q      <= retry_d;
            cnt_q        <= cnt_d;
            seg_idx_q    <= seg_idx_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            busy_q       <= busy_d;
            spawn_fail_q <= spawn_fail_d;
        end
    end

    assign seg_idx    = seg_idx_q;
    assign food_X     = food_x_q;
    assign food_Y     = food_y_q;
    assign food_valid = food_valid_q;
    assign busy       = busy_q;
    assign spawn_fail = spawn_fail_q;

endmodule

// File: tb/tb_food_spawner.sv
// Scoreboarded bench for food_spawner: directed spawns push expected commits, a monitor checks them.
module tb_food_spawner;

    logic       VGA_clk = 1'b0;
    logic       reset;
    logic       spawn_req;
    logic [9:0] rand_X, rand_Y;
    logic [6:0] snake_len;
    logic [5:0] seg_idx;
    logic [9:0] seg_X = '0, seg_Y = '0;
    logic [9:0] food_X, food_Y;
    logic       food_valid, busy, spawn_fail;

    food_spawner dut (
        .VGA_clk    (VGA_clk),
        .reset      (reset),
        .spawn_req  (spawn_req),
        .rand_X     (rand_X),
        .rand_Y     (rand_Y),
        .snake_len  (snake_len),
        .seg_idx    (seg_idx),
        .seg_X      (seg_X),
        .seg_Y      (seg_Y),
        .food_X     (food_X),
        .food_Y     (food_Y),
        .food_valid (food_valid),
        .busy       (busy),
        .spawn_fail (spawn_fail)
    );

    always #5 VGA_clk = ~VGA_clk;

    logic [9:0] mem_x [64];
    logic [9:0] mem_y [64];

    always @(posedge VGA_clk) begin
        seg_X <= mem_x[seg_idx];
        seg_Y <= mem_y[seg_idx];
    end

    int cyc = 0;
    always @(posedge VGA_clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        int         at;
        bit         fail;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_exp(input int x, input int y, input int at, input bit fail);
        exp_t e;
        e.x = 10'(x);
        e.y = 10'(y);
        e.at = at;
        e.fail = fail;
        exp_q.push_back(e);
    endtask

    // Returns at the falling edge right after the sampling edge; s is that edge's cycle number.
    task automatic spawn_pulse(output int s);
        @(negedge VGA_clk);
        spawn_req = 1'b1;
        s = cyc + 1;
        @(negedge VGA_clk);
        spawn_req = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge VGA_clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d commits still outstanding, expected 0", exp_q.size());
        end
    endtask

    // Monitor: every rising food_valid is a commit and consumes one expected entry.
    bit prev_valid = 1'b0;
    bit fail_seen  = 1'b0;
    int fail_w     = 0;

    always @(negedge VGA_clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            fail_seen  = 1'b0;
            fail_w     = 0;
        end else begin
            if (food_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_commit: got food=(%0d,%0d), expected no commit", food_X, food_Y);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("food_x", food_X, e.x);
                    check("food_y", food_Y, e.y);
                    check("commit_cycle", cyc, e.at);
                    check("spawn_fail_seen", fail_seen, e.fail);
                end
                fail_seen = 1'b0;
            end
            if (spawn_fail) begin
                fail_seen = 1'b1;
                fail_w++;
            end else if (fail_w != 0) begin
                check("spawn_fail_width", fail_w, 1);
                fail_w = 0;
            end
            prev_valid = food_valid;
        end
    end

    int s;
    int exp_idx[6] = '{0, 0, 1, 2, 3, 3};

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_x[i] = '0;
            mem_y[i] = '0;
        end
        reset = 1'b1;
        spawn_req = 1'b0;
        rand_X = '0;
        rand_Y = '0;
        snake_len = '0;
        #1;
        check("rst_food_x", food_X, 320);
        check("rst_food_y", food_Y, 240);
        check("rst_food_valid", food_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_spawn_fail", spawn_fail, 0);
        check("rst_seg_idx", seg_idx, 0);
        repeat (2) @(negedge VGA_clk);
        reset = 1'b0;

        // Bounds test only
        snake_len = 7'd0;
        rand_X = 10'd300;
        rand_Y = 10'd200;
        spawn_pulse(s);
        push_exp(300, 200, s + 3, 1'b0);
        check("t2_busy", busy, 1);
        check("t2_valid_low", food_valid, 0);
        wait_drain(20);

        // Reset in the middle of a scan abandons the spawn
        snake_len = 7'd10;
        rand_X = 10'd400;
        rand_Y = 10'd300;
        spawn_pulse(s);
        repeat (3) @(negedge VGA_clk);
        #2 reset = 1'b1;
        #1;
        check("t1_food_x", food_X, 320);
        check("t1_food_y", food_Y, 240);
        check("t1_food_valid", food_valid, 0);
        check("t1_busy", busy, 0);
        check("t1_seg_idx", seg_idx, 0);
        @(negedge VGA_clk);
        reset = 1'b0;
        repeat (20) @(negedge VGA_clk);
        check("t1_no_commit", food_valid, 0);
        check("t1_idle", busy, 0);

        // Clean four-segment scan
        mem_x[0] = 10'd100; mem_y[0] = 10'd100;
        mem_x[1] = 10'd110; mem_y[1] = 10'd100;
        mem_x[2] = 10'd120; mem_y[2] = 10'd100;
        mem_x[3] = 10'd130; mem_y[3] = 10'd100;
        snake_len = 7'd4;
        rand_X = 10'd300;
        rand_Y = 10'd200;
        spawn_pulse(s);
        push_exp(300, 200, s + 7, 1'b0);
        check("t3_seg_idx_c0", seg_idx, exp_idx[0]);
        for (int i = 1; i < 6; i++) begin
            @(negedge VGA_clk);
            check("t3_seg_idx", seg_idx, exp_idx[i]);
        end
        wait_drain(20);

        // Hit on segment 2 forces a re-draw
        mem_x[2] = 10'd300; mem_y[2] = 10'd200;
        spawn_pulse(s);
        rand_X = 10'd330;
        rand_Y = 10'd210;
        push_exp(330, 210, s + 12, 1'b0);
        repeat (11) @(negedge VGA_clk);
        check("t4_busy_commit", busy, 1);
        check("t4_valid_commit", food_valid, 0);
        @(negedge VGA_clk);
        check("t4_busy_done", busy, 0);
        wait_drain(20);
        mem_x[2] = 10'd120; mem_y[2] = 10'd100;

        // Out-of-bounds X then corner-legal candidate; extra request while busy
        rand_X = 10'd630;
        rand_Y = 10'd200;
        spawn_pulse(s);
        rand_X = 10'd20;
        rand_Y = 10'd460;
        push_exp(20, 460, s + 8, 1'b0);
        repeat (2) @(negedge VGA_clk);
        spawn_req = 1'b1;
        @(negedge VGA_clk);
        spawn_req = 1'b0;
        wait_drain(20);
        repeat (15) @(negedge VGA_clk);
        check("t5_idle", busy, 0);

        // Every candidate collides: forced commit after 16 tries
        mem_x[0] = 10'd200; mem_y[0] = 10'd200;
        snake_len = 7'd1;
        rand_X = 10'd200;
        rand_Y = 10'd200;
        spawn_pulse(s);
        push_exp(200, 200, s + 49, 1'b1);
        repeat (47) @(negedge VGA_clk);
        check("t6_no_early_fail", spawn_fail, 0);
        @(negedge VGA_clk);
        check("t6_fail_pulse", spawn_fail, 1);
        @(negedge VGA_clk);
        check("t6_fail_cleared", spawn_fail, 0);
        check("t6_valid", food_valid, 1);
        wait_drain(20);

        repeat (5) @(negedge VGA_clk);
        check("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
